// File: rtl/hdc_pkg.sv
// Shared types and defaults for the HDC message path (sender, scheduler, encoder).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hdc_pkg;

    // Defaults every HDC block instantiates with, so the sender, encoder and
    // scheduler agree on bus widths and pass length.
    localparam int HDC_MAX_LENGTH = 200;
    localparam int HDC_MSG_NUMS   = 100;
    localparam int HDC_CNT_W      = 16;
    localparam int HDC_TIMEOUT    = 4096;

    // Class labels; codes 2 and 3 are reserved and mark a message as unusable.
    localparam logic [1:0] LBL_HAM  = 2'd0;
    localparam logic [1:0] LBL_SPAM = 2'd1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_STREAM    = 2'd1,
        ST_WAIT_PRED = 2'd2,
        ST_DONE      = 2'd3
    } sched_state_t;

    // A label is scoreable only if it is one of the two defined classes.
    function automatic logic label_ok(input logic [1:0] lbl);
        return (lbl == LBL_HAM) || (lbl == LBL_SPAM);
    endfunction

endpackage

// File: rtl/hdc_eval_stats.sv
// Saturating pass statistics (total/correct/skipped/timed-out) with end-of-pass pulse.
// Latency: event strobe in cycle C -> counter updated in C+1; pass_done in the cycle after the final commit.
// Backpressure: none; strobes are single-cycle and always accepted.
module hdc_eval_stats #(
    parameter int CNT_W    = 16,
    parameter int MSG_NUMS = 100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             score_en,
    input  logic             match,
    input  logic             skip,
    input  logic             tmo,
    input  logic             commit,
    output logic [CNT_W-1:0] total_cnt,
    output logic [CNT_W-1:0] correct_cnt,
    output logic [CNT_W-1:0] skip_cnt,
    output logic [CNT_W-1:0] tmo_cnt,
    output logic             pass_done
);

    // Increment unless already at the all-ones ceiling.
    function automatic logic [CNT_W-1:0] bump(input logic [CNT_W-1:0] v, input logic en);
        if (en && !(&v)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    logic [CNT_W-1:0] total_nxt;
    logic [CNT_W-1:0] correct_nxt;
    logic [CNT_W-1:0] skip_nxt;
    logic [CNT_W-1:0] tmo_nxt;

    // The cycle showing pass_done is the one that clears; an event landing in
    // that same cycle is counted against the fresh pass rather than lost.
    always_comb begin
        total_nxt   = bump(pass_done ? '0 : total_cnt,   commit);
        correct_nxt = bump(pass_done ? '0 : correct_cnt, score_en && match);
        skip_nxt    = bump(pass_done ? '0 : skip_cnt,    skip);
        tmo_nxt     = bump(pass_done ? '0 : tmo_cnt,     tmo);
    end

    // Counter registers and the end-of-pass strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
            skip_cnt    <= '0;
            tmo_cnt     <= '0;
            pass_done   <= 1'b0;
        end else begin
            total_cnt   <= total_nxt;
            correct_cnt <= correct_nxt;
            skip_cnt    <= skip_nxt;
            tmo_cnt     <= tmo_nxt;
            pass_done   <= commit && (total_nxt == CNT_W'(MSG_NUMS));
        end
    end

endmodule

// File: rtl/hdc_msg_sched.sv
// Captures a message, streams it bytewise to the HDC encoder, scores the prediction and advances the sender.
// Latency: msg_valid T -> char_valid T+1; last handshake S -> WAIT_PRED S+1; pred_valid P -> compute_done P+1.
// Backpressure: char_data/char_last held while char_valid && !char_ready; msg_valid dropped outside IDLE.
module hdc_msg_sched
    import hdc_pkg::*;
#(
    parameter int MAX_LENGTH = HDC_MAX_LENGTH,
    parameter int MSG_NUMS   = HDC_MSG_NUMS,
    parameter int CNT_W      = HDC_CNT_W,
    parameter int TIMEOUT    = HDC_TIMEOUT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [MAX_LENGTH*8-1:0] msg,
    input  logic                    msg_valid,
    input  logic [7:0]              length,
    input  logic [1:0]              label,
    output logic                    compute_done,
    output logic [7:0]              char_data,
    output logic                    char_valid,
    output logic                    char_last,
    input  logic                    char_ready,
    input  logic                    pred_valid,
    input  logic [1:0]              pred_label,
    output logic [CNT_W-1:0]        total_cnt,
    output logic [CNT_W-1:0]        correct_cnt,
    output logic [CNT_W-1:0]        skip_cnt,
    output logic [CNT_W-1:0]        tmo_cnt,
    output logic                    match,
    output logic                    pass_done
);

    localparam int IDX_W  = (MAX_LENGTH > 1) ? $clog2(MAX_LENGTH) : 1;
    localparam int WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    sched_state_t                  state;
    logic [MAX_LENGTH-1:0][7:0]    msg_q;
    logic [7:0]                    len_q;
    logic [1:0]                    lbl_q;
    logic [IDX_W-1:0]              idx;
    logic [WCNT_W-1:0]             wcnt;

    logic [7:0] eff_len;
    logic       msg_ok;
    logic       last_byte;
    logic       wcnt_term;
    logic       pred_hit;
    logic       score_ev;
    logic       skip_ev;
    logic       tmo_ev;
    logic       commit;

    // Clamp the requested length to the bus capacity and decide if the message is usable.
    always_comb begin
        eff_len = length;
        if (32'(length) > MAX_LENGTH) begin
            eff_len = 8'(MAX_LENGTH);
        end
        msg_ok = (eff_len != 8'd0) && label_ok(label);
    end

    // Byte serializer view of the capture register plus per-state event strobes.
    always_comb begin
        last_byte  = (32'(idx) + 32'd1) == 32'(len_q);
        wcnt_term  = 32'(wcnt) == (TIMEOUT - 1);
        pred_hit   = (pred_label == lbl_q);
        char_data  = char_valid ? msg_q[idx] : 8'd0;
        char_last  = char_valid && last_byte;
        score_ev   = (state == ST_WAIT_PRED) && pred_valid;
        tmo_ev     = (state == ST_WAIT_PRED) && !pred_valid && wcnt_term;
        skip_ev    = (state == ST_IDLE) && msg_valid && !msg_ok;
        commit     = (state == ST_DONE);
    end

    // Main controller: capture, stream, wait for prediction, report.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            msg_q        <= '0;
            len_q        <= '0;
            lbl_q        <= '0;
            idx          <= '0;
            wcnt         <= '0;
            char_valid   <= 1'b0;
            compute_done <= 1'b0;
            match        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (msg_valid) begin
                        msg_q <= msg;
                        len_q <= eff_len;
                        lbl_q <= label;
                        idx   <= '0;
                        if (msg_ok) begin
                            state      <= ST_STREAM;
                            char_valid <= 1'b1;
                        end else begin
                            state        <= ST_DONE;
                            compute_done <= 1'b1;
                        end
                    end
                end
                ST_STREAM: begin
                    // char_valid is high for the whole state, so ready alone is the handshake.
                    if (char_ready) begin
                        if (last_byte) begin
                            state      <= ST_WAIT_PRED;
                            char_valid <= 1'b0;
                            wcnt       <= '0;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                ST_WAIT_PRED: begin
                    // A prediction on the terminal cycle takes priority over the timeout.
                    if (pred_valid) begin
                        match        <= pred_hit;
                        state        <= ST_DONE;
                        compute_done <= 1'b1;
                    end else if (wcnt_term) begin
                        match        <= 1'b0;
                        state        <= ST_DONE;
                        compute_done <= 1'b1;
                    end else begin
                        wcnt <= wcnt + WCNT_W'(1);
                    end
                end
                ST_DONE: begin
                    compute_done <= 1'b0;
                    state        <= ST_IDLE;
                end
                default: begin
                    state        <= ST_IDLE;
                    char_valid   <= 1'b0;
                    compute_done <= 1'b0;
                end
            endcase
        end
    end

    hdc_eval_stats #(
        .CNT_W    (CNT_W),
        .MSG_NUMS (MSG_NUMS)
    ) u_stats (
        .clk         (clk),
        .rst_n       (rst_n),
        .score_en    (score_ev),
        .match       (pred_hit),
        .skip        (skip_ev),
        .tmo         (tmo_ev),
        .commit      (commit),
        .total_cnt   (total_cnt),
        .correct_cnt (correct_cnt),
        .skip_cnt    (skip_cnt),
        .tmo_cnt     (tmo_cnt),
        .pass_done   (pass_done)
    );

endmodule

// File: tb/tb_hdc_msg_sched.sv
// Directed bench for hdc_msg_sched with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1 ns after each rising edge.
// Backpressure: char_ready driven from per-cycle patterns.
module tb_hdc_msg_sched;

    localparam int ML = 200;
    localparam int MN = 4;
    localparam int CW = 16;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [ML*8-1:0] msg;
    logic            msg_valid;
    logic [7:0]      length;
    logic [1:0]      label;
    logic            compute_done;
    logic [7:0]      char_data;
    logic            char_valid;
    logic            char_last;
    logic            char_ready;
    logic            pred_valid;
    logic [1:0]      pred_label;
    logic [CW-1:0]   total_cnt;
    logic [CW-1:0]   correct_cnt;
    logic [CW-1:0]   skip_cnt;
    logic [CW-1:0]   tmo_cnt;
    logic            match;
    logic            pass_done;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] eb [ML];

    always #5 clk = ~clk;

    hdc_msg_sched #(
        .MAX_LENGTH (ML),
        .MSG_NUMS   (MN),
        .CNT_W      (CW),
        .TIMEOUT    (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .msg          (msg),
        .msg_valid    (msg_valid),
        .length       (length),
        .label        (label),
        .compute_done (compute_done),
        .char_data    (char_data),
        .char_valid   (char_valid),
        .char_last    (char_last),
        .char_ready   (char_ready),
        .pred_valid   (pred_valid),
        .pred_label   (pred_label),
        .total_cnt    (total_cnt),
        .correct_cnt  (correct_cnt),
        .skip_cnt     (skip_cnt),
        .tmo_cnt      (tmo_cnt),
        .match        (match),
        .pass_done    (pass_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pack_msg;
        for (int i = 0; i < ML; i++) msg[8*i +: 8] = eb[i];
    endtask

    task automatic do_reset;
        rst_n      = 1'b0;
        msg_valid  = 1'b0;
        char_ready = 1'b0;
        pred_valid = 1'b0;
        pred_label = 2'd0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    task automatic start_msg(input logic [7:0] len, input logic [1:0] lbl);
        length    = len;
        label     = lbl;
        msg_valid = 1'b1;
        tick;
        msg_valid = 1'b0;
    endtask

    // Streams n bytes; ready follows rdy_pat for the first pat_len cycles, then stays high.
    task automatic stream(input int n, input logic [15:0] rdy_pat, input int pat_len, input int exp_cyc);
        int   k;
        int   cyc;
        logic r;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < n + 40) begin
            r = (cyc < pat_len) ? rdy_pat[cyc] : 1'b1;
            chk("char_valid", {31'd0, char_valid}, 32'd1);
            chk("char_data", {24'd0, char_data}, {24'd0, eb[k]});
            chk("char_last", {31'd0, char_last}, {31'd0, (k == n - 1)});
            char_ready = r;
            tick;
            if (r) k++;
            cyc++;
        end
        char_ready = 1'b0;
        chk("handshakes", k, n);
        chk("stream_cycles", cyc, exp_cyc);
        chk("valid_drop", {31'd0, char_valid}, 32'd0);
    endtask

    task automatic send_pred(input logic [1:0] pl);
        pred_label = pl;
        pred_valid = 1'b1;
        tick;
        pred_valid = 1'b0;
    endtask

    logic [1:0] p_lbl  [4] = '{2'd1, 2'd0, 2'd1, 2'd0};
    logic [1:0] p_pred [4] = '{2'd1, 2'd1, 2'd1, 2'd0};
    int         p_corr [4] = '{1, 1, 2, 3};

    initial begin
        int k;
        msg    = '0;
        length = 8'd0;
        label  = 2'd0;
        for (int i = 0; i < ML; i++) eb[i] = 8'd0;

        // Reset values
        do_reset;
        chk("rst_compute_done", {31'd0, compute_done}, 32'd0);
        chk("rst_char_valid", {31'd0, char_valid}, 32'd0);
        chk("rst_char_last", {31'd0, char_last}, 32'd0);
        chk("rst_char_data", {24'd0, char_data}, 32'd0);
        chk("rst_total", {16'd0, total_cnt}, 32'd0);
        chk("rst_correct", {16'd0, correct_cnt}, 32'd0);
        chk("rst_skip", {16'd0, skip_cnt}, 32'd0);
        chk("rst_tmo", {16'd0, tmo_cnt}, 32'd0);
        chk("rst_match", {31'd0, match}, 32'd0);
        chk("rst_pass_done", {31'd0, pass_done}, 32'd0);

        // "abc", label spam, ready high, correct prediction
        eb[0] = 8'h61; eb[1] = 8'h62; eb[2] = 8'h63;
        pack_msg;
        start_msg(8'd3, 2'd1);
        stream(3, 16'h0, 0, 3);
        chk("abc_wait_cd", {31'd0, compute_done}, 32'd0);
        send_pred(2'd1);
        chk("abc_cd", {31'd0, compute_done}, 32'd1);
        chk("abc_match", {31'd0, match}, 32'd1);
        chk("abc_correct", {16'd0, correct_cnt}, 32'd1);
        tick;
        chk("abc_cd_pulse", {31'd0, compute_done}, 32'd0);
        chk("abc_total", {16'd0, total_cnt}, 32'd1);

        // Backpressure 1,0,0,1 on a 4-byte message
        do_reset;
        eb[0] = 8'h77; eb[1] = 8'h78; eb[2] = 8'h79; eb[3] = 8'h7a;
        pack_msg;
        start_msg(8'd4, 2'd0);
        stream(4, 16'h0009, 4, 6);
        send_pred(2'd0);
        chk("bp_cd", {31'd0, compute_done}, 32'd1);
        chk("bp_match", {31'd0, match}, 32'd1);

        // Zero length is skipped
        do_reset;
        start_msg(8'd0, 2'd0);
        chk("len0_valid", {31'd0, char_valid}, 32'd0);
        chk("len0_cd", {31'd0, compute_done}, 32'd1);
        tick;
        chk("len0_skip", {16'd0, skip_cnt}, 32'd1);
        chk("len0_total", {16'd0, total_cnt}, 32'd1);

        // Invalid label is skipped
        do_reset;
        start_msg(8'd5, 2'd3);
        chk("lbl3_valid", {31'd0, char_valid}, 32'd0);
        chk("lbl3_cd", {31'd0, compute_done}, 32'd1);
        tick;
        chk("lbl3_skip", {16'd0, skip_cnt}, 32'd1);
        chk("lbl3_total", {16'd0, total_cnt}, 32'd1);

        // Length 255 clamps to 200 bytes, then no prediction -> timeout
        do_reset;
        for (int i = 0; i < ML; i++) eb[i] = 8'(i) ^ 8'h5a;
        pack_msg;
        start_msg(8'd255, 2'd1);
        stream(ML, 16'h0, 0, ML);
        k = 0;
        while (!compute_done && k < 40) begin
            tick;
            k++;
        end
        chk("tmo_latency", k, TO);
        chk("tmo_cnt", {16'd0, tmo_cnt}, 32'd1);
        chk("tmo_match", {31'd0, match}, 32'd0);
        chk("tmo_correct", {16'd0, correct_cnt}, 32'd0);
        tick;
        chk("tmo_total", {16'd0, total_cnt}, 32'd1);

        // Prediction on the terminal cycle wins over the timeout
        eb[0] = 8'hc3;
        pack_msg;
        start_msg(8'd1, 2'd0);
        stream(1, 16'h0, 0, 1);
        repeat (TO - 1) tick;
        chk("term_no_cd", {31'd0, compute_done}, 32'd0);
        send_pred(2'd0);
        chk("term_cd", {31'd0, compute_done}, 32'd1);
        chk("term_match", {31'd0, match}, 32'd1);
        chk("term_tmo", {16'd0, tmo_cnt}, 32'd1);
        chk("term_correct", {16'd0, correct_cnt}, 32'd1);
        tick;
        chk("term_total", {16'd0, total_cnt}, 32'd2);

        // Full pass of 4: correct, wrong, correct, correct
        do_reset;
        eb[0] = 8'h68; eb[1] = 8'h69;
        pack_msg;
        for (int m = 0; m < 4; m++) begin
            start_msg(8'd2, p_lbl[m]);
            stream(2, 16'h0, 0, 2);
            send_pred(p_pred[m]);
            chk("pass_cd", {31'd0, compute_done}, 32'd1);
            tick;
            chk("pass_done", {31'd0, pass_done}, {31'd0, (m == 3)});
            chk("pass_total", {16'd0, total_cnt}, m + 1);
            chk("pass_correct", {16'd0, correct_cnt}, p_corr[m]);
        end
        tick;
        chk("pass_done_clear", {31'd0, pass_done}, 32'd0);
        chk("pass_total_clear", {16'd0, total_cnt}, 32'd0);
        chk("pass_correct_clear", {16'd0, correct_cnt}, 32'd0);

        // Asynchronous reset in the middle of STREAM
        start_msg(8'd0, 2'd0);
        tick;
        chk("pre_rst_skip", {16'd0, skip_cnt}, 32'd1);
        chk("pre_rst_total", {16'd0, total_cnt}, 32'd1);
        for (int i = 0; i < 5; i++) eb[i] = 8'h30 + 8'(i);
        pack_msg;
        start_msg(8'd5, 2'd1);
        char_ready = 1'b1;
        tick;
        tick;
        chk("pre_rst_valid", {31'd0, char_valid}, 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, char_valid}, 32'd0);
        chk("arst_data", {24'd0, char_data}, 32'd0);
        chk("arst_cd", {31'd0, compute_done}, 32'd0);
        chk("arst_total", {16'd0, total_cnt}, 32'd0);
        chk("arst_skip", {16'd0, skip_cnt}, 32'd0);
        char_ready = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
